// File: rtl/cevero_dvfs.sv
// Closed-loop DVFS controller: counts detector error events per observation
// window, raises voltage (then lowers frequency) on bad windows and relaxes after quiet ones.
module cevero_dvfs #(
  parameter int unsigned WINDOW_CYCLES = 100,
  parameter int unsigned ERR_THRESHOLD = 4,
  parameter int unsigned QUIET_WINDOWS = 10,
  parameter int unsigned MAX_VOLTAGE   = 7,
  parameter int unsigned FREQ_STEP     = 10,
  parameter int unsigned MIN_FREQ      = 50
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        error_i,
  input  logic [2:0]  def_voltage_i,
  input  logic [31:0] def_freq_i,
  output logic [2:0]  set_voltage_o,
  output logic [31:0] set_freq_o
);

  localparam int WIN_W = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
  localparam int QW_W  = $clog2(QUIET_WINDOWS + 1);

  typedef enum logic {
    ST_INIT,
    ST_MONITOR
  } state_t;

  state_t             r_state;
  logic [WIN_W-1:0]   r_window_cnt;
  logic [QW_W-1:0]    r_quiet_cnt;
  logic [7:0]         r_error_counter;
  logic               r_error_q;
  logic [2:0]         r_voltage;
  logic [31:0]        r_freq;

  logic               w_event;
  logic               w_window_end;
  logic [7:0]         w_count_inc;
  logic [7:0]         w_count_eval;
  logic               w_bad;
  logic               w_clean;
  logic               w_volt_at_max;
  logic [32:0]        w_freq_dec_lim;
  logic [31:0]        w_freq_dec;
  logic [32:0]        w_freq_sum;
  logic [31:0]        w_freq_inc;
  logic [QW_W-1:0]    w_quiet_next;
  logic               w_relax;

  // A held error level counts once: only the 0->1 transition is an event.
  assign w_event      = error_i & ~r_error_q;
  assign w_window_end = (r_window_cnt == WIN_W'(WINDOW_CYCLES - 1));

  // The closing window's verdict includes an event that lands on its last cycle.
  assign w_count_inc  = (r_error_counter == 8'hFF) ? 8'hFF : r_error_counter + 8'd1;
  assign w_count_eval = w_event ? w_count_inc : r_error_counter;
  assign w_bad        = (w_count_eval >= 8'(ERR_THRESHOLD));
  assign w_clean      = (w_count_eval == 8'd0);

  assign w_volt_at_max  = (r_voltage >= 3'(MAX_VOLTAGE));
  assign w_freq_dec_lim = 33'(MIN_FREQ) + 33'(FREQ_STEP);
  assign w_freq_dec     = ({1'b0, r_freq} >= w_freq_dec_lim) ? (r_freq - 32'(FREQ_STEP))
                                                             : 32'(MIN_FREQ);
  // 33-bit sum so the cap against the nominal frequency cannot be fooled by wrap-around.
  assign w_freq_sum     = {1'b0, r_freq} + 33'(FREQ_STEP);
  assign w_freq_inc     = (w_freq_sum > {1'b0, def_freq_i}) ? def_freq_i : w_freq_sum[31:0];

  assign w_quiet_next = r_quiet_cnt + QW_W'(1);
  assign w_relax      = (w_quiet_next >= QW_W'(QUIET_WINDOWS));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state         <= ST_INIT;
      r_window_cnt    <= '0;
      r_quiet_cnt     <= '0;
      r_error_counter <= 8'd0;
      r_error_q       <= 1'b0;
      r_voltage       <= 3'd0;
      r_freq          <= 32'd0;
    end else begin
      r_error_q <= error_i;
      case (r_state)
        ST_INIT: begin
          r_voltage       <= def_voltage_i;
          r_freq          <= def_freq_i;
          r_window_cnt    <= '0;
          r_error_counter <= 8'd0;
          r_state         <= ST_MONITOR;
        end
        ST_MONITOR: begin
          if (w_window_end) begin
            r_window_cnt    <= '0;
            r_error_counter <= w_event ? 8'd1 : 8'd0;
            if (w_bad) begin
              r_quiet_cnt <= '0;
              if (!w_volt_at_max) begin
                r_voltage <= r_voltage + 3'd1;
              end else begin
                r_freq <= w_freq_dec;
              end
            end else if (w_clean) begin
              if (w_relax) begin
                // Restore frequency first, then back voltage off toward nominal.
                r_quiet_cnt <= '0;
                if (r_freq < def_freq_i) begin
                  r_freq <= w_freq_inc;
                end else if (r_voltage > def_voltage_i) begin
                  r_voltage <= r_voltage - 3'd1;
                end
              end else begin
                r_quiet_cnt <= w_quiet_next;
              end
            end else begin
              r_quiet_cnt <= '0;
            end
          end else begin
            r_window_cnt    <= r_window_cnt + WIN_W'(1);
            r_error_counter <= w_count_eval;
          end
        end
        default: r_state <= ST_INIT;
      endcase
    end
  end

  assign set_voltage_o = r_voltage;
  assign set_freq_o    = r_freq;

endmodule

// File: tb/tb_cevero_dvfs.sv
// Self-checking bench for cevero_dvfs: randomized error bursts checked
// against a window-level behavioural model of the DVFS policy.
module tb_cevero_dvfs;

  localparam int WIN   = 100;
  localparam int THR   = 4;
  localparam int QUIET = 10;
  localparam int VMAX  = 7;
  localparam int FSTEP = 10;
  localparam int FMIN  = 50;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        error_i = 1'b0;
  logic [2:0]  def_voltage_i = 3'd5;
  logic [31:0] def_freq_i = 32'd150;
  logic [2:0]  set_voltage_o;
  logic [31:0] set_freq_o;

  int n_compared = 0;
  int n_failed   = 0;

  // Reference model state
  int     m_v, m_cnt, m_win, m_quiet;
  longint m_f;
  bit     m_init, m_prev;

  cevero_dvfs dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .error_i       (error_i),
    .def_voltage_i (def_voltage_i),
    .def_freq_i    (def_freq_i),
    .set_voltage_o (set_voltage_o),
    .set_freq_o    (set_freq_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic model_reset();
    m_v = 0; m_f = 0; m_cnt = 0; m_win = 0; m_quiet = 0;
    m_init = 1'b1; m_prev = 1'b0;
  endtask

  // One clock of the policy: event detection, window bookkeeping, window verdict.
  task automatic model_step();
    bit ev;
    int total;
    if (!rst_ni) begin
      model_reset();
      return;
    end
    ev = (error_i === 1'b1) && !m_prev;
    m_prev = (error_i === 1'b1);
    if (m_init) begin
      m_v = int'(def_voltage_i); m_f = longint'(def_freq_i);
      m_win = 0; m_cnt = 0; m_init = 1'b0;
      return;
    end
    if (m_win == WIN - 1) begin
      total = m_cnt + int'(ev);
      if (total > 255) total = 255;
      if (total >= THR) begin
        m_quiet = 0;
        if (m_v < VMAX) m_v = m_v + 1;
        else m_f = (m_f - FSTEP < FMIN) ? FMIN : m_f - FSTEP;
      end else if (total == 0) begin
        m_quiet = m_quiet + 1;
        if (m_quiet == QUIET) begin
          m_quiet = 0;
          if (m_f < longint'(def_freq_i))
            m_f = (m_f + FSTEP > longint'(def_freq_i)) ? longint'(def_freq_i) : m_f + FSTEP;
          else if (m_v > int'(def_voltage_i))
            m_v = m_v - 1;
        end
      end else begin
        m_quiet = 0;
      end
      m_cnt = int'(ev);
      m_win = 0;
    end else begin
      m_cnt = (m_cnt + int'(ev) > 255) ? 255 : m_cnt + int'(ev);
      m_win = m_win + 1;
    end
  endtask

  task automatic tick(input bit err);
    error_i = err;
    @(posedge clk_i);
    model_step();
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b0);
  endtask

  // k error pulses of random 1..2 cycle width separated by 1..3 quiet cycles.
  task automatic pulse_burst(input int k);
    for (int p = 0; p < k; p++) begin
      repeat ($urandom_range(1, 2)) tick(1'b1);
      repeat ($urandom_range(1, 3)) tick(1'b0);
    end
  endtask

  task automatic align_window();
    for (int g = 0; g < WIN && m_win != 0; g++) tick(1'b0);
  endtask

  task automatic finish_window();
    int g = 0;
    do begin
      tick(1'b0);
      g++;
    end while (m_win != 0 && g < WIN + 1);
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    def_voltage_i = 3'd5;
    def_freq_i = 32'd150;
    model_reset();
    idle(3);
    n_compared++;
    if (set_voltage_o !== 3'd0 || set_freq_o !== 32'd0) begin
      n_failed++;
      $display("[TB] FAIL reset_outputs: got %0d/%0d expected 0/0", set_voltage_o, set_freq_o);
    end
    n_compared++;
    if (dut.r_error_counter !== 8'd0) begin
      n_failed++;
      $display("[TB] FAIL reset_counter: got %0d expected 0", dut.r_error_counter);
    end
    rst_ni = 1'b1;
    tick(1'b0);
    n_compared++;
    if (set_voltage_o !== 3'(m_v) || set_freq_o !== 32'(m_f) || set_voltage_o !== 3'd5) begin
      n_failed++;
      $display("[TB] FAIL init_load: got %0d/%0d expected %0d/%0d", set_voltage_o, set_freq_o, m_v, m_f);
    end
    n_compared++;
    if (dut.r_error_counter !== 8'd0) begin
      n_failed++;
      $display("[TB] FAIL init_counter: got %0d expected 0", dut.r_error_counter);
    end
  endtask

  task automatic test_bad_window();
    align_window();
    pulse_burst(4);
    n_compared++;
    if (dut.r_error_counter !== 8'd4) begin
      n_failed++;
      $display("[TB] FAIL bad_count: got %0d expected 4", dut.r_error_counter);
    end
    finish_window();
    n_compared++;
    if (set_voltage_o !== 3'(m_v) || set_freq_o !== 32'(m_f) || set_voltage_o !== 3'd6) begin
      n_failed++;
      $display("[TB] FAIL bad_raise: got %0d/%0d expected %0d/%0d", set_voltage_o, set_freq_o, m_v, m_f);
    end
    n_compared++;
    if (dut.r_error_counter !== 8'd0) begin
      n_failed++;
      $display("[TB] FAIL bad_clear: got %0d expected 0", dut.r_error_counter);
    end
  endtask

  task automatic test_relax();
    for (int w = 1; w <= 210; w++) begin
      finish_window();
      n_compared++;
      if (set_voltage_o !== 3'(m_v) || set_freq_o !== 32'(m_f)) begin
        n_failed++;
        $display("[TB] FAIL relax_w%0d: got %0d/%0d expected %0d/%0d", w, set_voltage_o, set_freq_o, m_v, m_f);
      end
    end
    n_compared++;
    if (set_voltage_o !== 3'd5 || set_freq_o !== 32'd150) begin
      n_failed++;
      $display("[TB] FAIL relax_final: got %0d/%0d expected 5/150", set_voltage_o, set_freq_o);
    end
  endtask

  task automatic test_freq_step();
    for (int w = 1; w <= 23; w++) begin
      if (w <= 3) pulse_burst($urandom_range(4, 8));
      finish_window();
      n_compared++;
      if (set_voltage_o !== 3'(m_v) || set_freq_o !== 32'(m_f)) begin
        n_failed++;
        $display("[TB] FAIL freqstep_w%0d: got %0d/%0d expected %0d/%0d", w, set_voltage_o, set_freq_o, m_v, m_f);
      end
      if (w == 3) begin
        n_compared++;
        if (set_voltage_o !== 3'd7 || set_freq_o !== 32'd140) begin
          n_failed++;
          $display("[TB] FAIL freqstep_drop: got %0d/%0d expected 7/140", set_voltage_o, set_freq_o);
        end
      end
    end
    n_compared++;
    if (set_voltage_o !== 3'd6 || set_freq_o !== 32'd150) begin
      n_failed++;
      $display("[TB] FAIL freqstep_recover: got %0d/%0d expected 6/150", set_voltage_o, set_freq_o);
    end
  endtask

  task automatic test_mid_count();
    idle(5 * WIN);
    pulse_burst(3);
    for (int w = 1; w <= 11; w++) begin
      finish_window();
      n_compared++;
      if (set_voltage_o !== 3'(m_v) || set_freq_o !== 32'(m_f)) begin
        n_failed++;
        $display("[TB] FAIL midcount_w%0d: got %0d/%0d expected %0d/%0d", w, set_voltage_o, set_freq_o, m_v, m_f);
      end
      if (w == 10) begin
        n_compared++;
        if (set_voltage_o !== 3'd6) begin
          n_failed++;
          $display("[TB] FAIL midcount_hold: got %0d expected 6", set_voltage_o);
        end
      end
    end
    n_compared++;
    if (set_voltage_o !== 3'd5) begin
      n_failed++;
      $display("[TB] FAIL midcount_relax: got %0d expected 5", set_voltage_o);
    end
  endtask

  task automatic test_held_error();
    align_window();
    repeat (20) tick(1'b1);
    tick(1'b0);
    n_compared++;
    if (dut.r_error_counter !== 8'd1 || int'(dut.r_error_counter) != m_cnt) begin
      n_failed++;
      $display("[TB] FAIL held_count: got %0d expected 1", dut.r_error_counter);
    end
    finish_window();
    n_compared++;
    if (set_voltage_o !== 3'(m_v) || set_freq_o !== 32'(m_f)) begin
      n_failed++;
      $display("[TB] FAIL held_hold: got %0d/%0d expected %0d/%0d", set_voltage_o, set_freq_o, m_v, m_f);
    end
  endtask

  task automatic test_reset_mid(input logic [2:0] nv, input logic [31:0] nf);
    pulse_burst(2);
    idle($urandom_range(5, 40));
    rst_ni = 1'b0;
    model_reset();
    #1;
    n_compared++;
    if (set_voltage_o !== 3'd0 || set_freq_o !== 32'd0) begin
      n_failed++;
      $display("[TB] FAIL midreset_async: got %0d/%0d expected 0/0", set_voltage_o, set_freq_o);
    end
    def_voltage_i = nv;
    def_freq_i = nf;
    idle(2);
    rst_ni = 1'b1;
    tick(1'b0);
    n_compared++;
    if (set_voltage_o !== nv || set_freq_o !== nf || set_voltage_o !== 3'(m_v)) begin
      n_failed++;
      $display("[TB] FAIL midreset_reload: got %0d/%0d expected %0d/%0d", set_voltage_o, set_freq_o, nv, nf);
    end
  endtask

  task automatic test_freq_floor();
    for (int w = 1; w <= 45; w++) begin
      if (w <= 5) pulse_burst($urandom_range(4, 8));
      finish_window();
      n_compared++;
      if (set_voltage_o !== 3'(m_v) || set_freq_o !== 32'(m_f)) begin
        n_failed++;
        $display("[TB] FAIL floor_w%0d: got %0d/%0d expected %0d/%0d", w, set_voltage_o, set_freq_o, m_v, m_f);
      end
      if (w == 5) begin
        n_compared++;
        if (set_freq_o !== 32'd50) begin
          n_failed++;
          $display("[TB] FAIL floor_min: got %0d expected 50", set_freq_o);
        end
      end
    end
    n_compared++;
    if (set_voltage_o !== 3'd7 || set_freq_o !== 32'd85) begin
      n_failed++;
      $display("[TB] FAIL floor_cap: got %0d/%0d expected 7/85", set_voltage_o, set_freq_o);
    end
  endtask

  task automatic test_random();
    for (int w = 1; w <= 40; w++) begin
      pulse_burst(($urandom_range(0, 3) == 0) ? $urandom_range(1, 8) : 0);
      finish_window();
      n_compared++;
      if (set_voltage_o !== 3'(m_v) || set_freq_o !== 32'(m_f) || int'(dut.r_error_counter) != m_cnt) begin
        n_failed++;
        $display("[TB] FAIL random_w%0d: got %0d/%0d/%0d expected %0d/%0d/%0d", w,
                 set_voltage_o, set_freq_o, dut.r_error_counter, m_v, m_f, m_cnt);
      end
    end
  endtask

  initial begin
    test_reset();
    test_bad_window();
    test_relax();
    test_freq_step();
    test_mid_count();
    test_held_error();
    test_reset_mid(3'd7, 32'd85);
    test_freq_floor();
    test_reset_mid(3'($urandom_range(0, 5)), 32'($urandom_range(6, 30) * 10 + 5));
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
    $finish;
  end

endmodule
